// File: rtl/noc_vc_merge_arbiter.sv
// noc_vc_merge_arbiter: round-robin packet-locked arbiter merging virtual channels onto one path
module noc_vc_merge_arbiter #(
    parameter int CHANNELS = 4,
    parameter int PKT_MAX_FLITS = 16,
    localparam int IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int CW = $clog2(PKT_MAX_FLITS + 1)
) (
    input  logic                noc_clk,
    input  logic                noc_rst,
    input  logic [CHANNELS-1:0] i_req,
    input  logic [CHANNELS-1:0] i_vc_ready,
    input  logic                i_fire,
    input  logic                i_tail,
    output logic [CHANNELS-1:0] o_vc_grant,
    output logic [IW-1:0]       o_grant_idx,
    output logic                o_locked,
    output logic                o_err
);
    typedef enum logic {IDLE, LOCK} state_t;
    state_t state, state_n;
    logic [CHANNELS-1:0] elig, grant_n;
    logic [IW-1:0] rr_ptr, ptr_n, idx_n, nxt_ptr, arb_ptr, win;
    logic [CW-1:0] cnt, cnt_n;
    logic found, rel, wd_exp, last_flit, err_n;
    assign elig = i_req & i_vc_ready;
    assign o_locked = (state == LOCK);
    assign last_flit = (cnt == CW'(PKT_MAX_FLITS - 1));
    assign rel = o_locked && i_fire && (i_tail || last_flit);
    assign wd_exp = o_locked && i_fire && !i_tail && last_flit;
    assign nxt_ptr = (o_grant_idx == IW'(CHANNELS - 1)) ? '0 : o_grant_idx + 1'b1;
    assign arb_ptr = rel ? nxt_ptr : rr_ptr;
    // first eligible VC at or above arb_ptr, scanning downward so the smallest offset wins
    always_comb begin
        win = '0;
        found = 1'b0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (elig[(int'(arb_ptr) + k) % CHANNELS]) begin
                found = 1'b1;
                win = IW'((int'(arb_ptr) + k) % CHANNELS);
            end
        end
    end
    // next-state: arbitrate when idle or on release, otherwise hold the lock and count flits
    always_comb begin
        state_n = state;
        grant_n = o_vc_grant;
        idx_n = o_grant_idx;
        ptr_n = rr_ptr;
        cnt_n = cnt;
        err_n = o_err | wd_exp;
        if (state == IDLE || rel) begin
            state_n = found ? LOCK : IDLE;
            grant_n = found ? CHANNELS'(1) << win : '0;
            idx_n = found ? win : '0;
        end
        if (rel) begin
            ptr_n = nxt_ptr;
            cnt_n = '0;
        end else if (o_locked && i_fire) begin
            cnt_n = cnt + 1'b1;
        end
    end
    // state and output registers
    always_ff @(posedge noc_clk) begin
        if (noc_rst) begin
            state <= IDLE;
            rr_ptr <= '0;
            cnt <= '0;
            o_vc_grant <= '0;
            o_grant_idx <= '0;
            o_err <= 1'b0;
        end else begin
            state <= state_n;
            rr_ptr <= ptr_n;
            cnt <= cnt_n;
            o_vc_grant <= grant_n;
            o_grant_idx <= idx_n;
            o_err <= err_n;
        end
    end
endmodule

// File: tb/tb_noc_vc_merge_arbiter.sv
// tb_noc_vc_merge_arbiter: directed self-checking bench for the VC merge arbiter
module tb_noc_vc_merge_arbiter;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req, rdy;
    logic       fire, tail;
    logic [3:0] grant;
    logic [1:0] idx;
    logic       locked, err;
    int checks = 0;
    int errors = 0;

    noc_vc_merge_arbiter #(.CHANNELS(4), .PKT_MAX_FLITS(4)) dut (
        .noc_clk(clk), .noc_rst(rst), .i_req(req), .i_vc_ready(rdy),
        .i_fire(fire), .i_tail(tail), .o_vc_grant(grant), .o_grant_idx(idx),
        .o_locked(locked), .o_err(err)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1; req = 0; rdy = 4'hF; fire = 0; tail = 0;
        tick(2);
        rst = 0;
        checks++;
        if ({grant, idx, locked, err} !== 8'h00) begin
            errors++;
            $display("FAIL reset: grant=%b idx=%0d locked=%b err=%b, want all 0", grant, idx, locked, err);
        end
    endtask

    task automatic test_grant;
        req = 4'b0110; rdy = 4'hF;
        tick();
        checks++;
        if (grant !== 4'b0010 || idx !== 2'd1 || locked !== 1'b1) begin
            errors++;
            $display("FAIL first_grant: grant=%b idx=%0d locked=%b, want 0010/1/1", grant, idx, locked);
        end
    endtask

    task automatic test_back_to_back;
        fire = 1; tail = 0;
        tick(2);
        checks++;
        if (grant !== 4'b0010) begin
            errors++;
            $display("FAIL mid_packet: grant=%b, want 0010", grant);
        end
        tail = 1; req = 4'b0111;
        tick();
        fire = 0; tail = 0;
        checks++;
        if (grant !== 4'b0100 || idx !== 2'd2 || locked !== 1'b1) begin
            errors++;
            $display("FAIL zero_bubble: grant=%b idx=%0d locked=%b, want 0100/2/1", grant, idx, locked);
        end
    endtask

    task automatic test_hold;
        req = 4'b0001; rdy = 4'b1011;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (grant !== 4'b0100 || idx !== 2'd2) begin
                errors++;
                $display("FAIL hold_%0d: grant=%b idx=%0d, want 0100/2", i, grant, idx);
            end
        end
        rdy = 4'hF; fire = 1; tail = 1;
        tick();
        checks++;
        if (grant !== 4'b0001 || idx !== 2'd0) begin
            errors++;
            $display("FAIL wrap: grant=%b idx=%0d, want 0001/0", grant, idx);
        end
        req = 0;
        tick();
        fire = 0; tail = 0;
        checks++;
        if (grant !== 4'b0000 || locked !== 1'b0) begin
            errors++;
            $display("FAIL to_idle: grant=%b locked=%b, want 0000/0", grant, locked);
        end
    endtask

    task automatic test_idle_fire;
        fire = 1; tail = 1;
        tick(3);
        checks++;
        if (grant !== 4'b0000 || locked !== 1'b0) begin
            errors++;
            $display("FAIL idle_fire: grant=%b locked=%b, want 0000/0", grant, locked);
        end
        fire = 0; tail = 0; req = 4'hF;
        tick();
        checks++;
        if (grant !== 4'b0010) begin
            errors++;
            $display("FAIL idle_ptr: grant=%b, want 0010", grant);
        end
        req = 0; fire = 1; tail = 1;
        tick();
        fire = 0; tail = 0;
    endtask

    task automatic test_watchdog;
        req = 4'b0001;
        tick();
        req = 0;
        checks++;
        if (grant !== 4'b0001 || err !== 1'b0) begin
            errors++;
            $display("FAIL wd_grant: grant=%b err=%b, want 0001/0", grant, err);
        end
        fire = 1; tail = 0;
        tick(3);
        checks++;
        if (locked !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL wd_early: locked=%b err=%b, want 1/0", locked, err);
        end
        tick();
        fire = 0;
        checks++;
        if (locked !== 1'b0 || grant !== 4'b0000 || err !== 1'b1) begin
            errors++;
            $display("FAIL wd_expire: locked=%b grant=%b err=%b, want 0/0000/1", locked, grant, err);
        end
        req = 4'b0100;
        tick();
        req = 0;
        checks++;
        if (grant !== 4'b0100) begin
            errors++;
            $display("FAIL wd_next: grant=%b, want 0100", grant);
        end
        fire = 1; tail = 1;
        tick();
        fire = 0; tail = 0;
        checks++;
        if (err !== 1'b1 || locked !== 1'b0) begin
            errors++;
            $display("FAIL err_sticky: err=%b locked=%b, want 1/0", err, locked);
        end
    endtask

    task automatic test_credit;
        req = 4'b1000; rdy = 4'b0111;
        tick(3);
        checks++;
        if (grant !== 4'b0000 || locked !== 1'b0) begin
            errors++;
            $display("FAIL no_credit: grant=%b locked=%b, want 0000/0", grant, locked);
        end
        rdy = 4'hF;
        tick();
        checks++;
        if (grant !== 4'b1000 || idx !== 2'd3) begin
            errors++;
            $display("FAIL credit: grant=%b idx=%0d, want 1000/3", grant, idx);
        end
    endtask

    task automatic test_mid_reset;
        fire = 1; tail = 0;
        tick();
        req = 4'hF; fire = 0; rst = 1;
        tick();
        rst = 0;
        checks++;
        if ({grant, idx, locked, err} !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset: grant=%b idx=%0d locked=%b err=%b, want all 0", grant, idx, locked, err);
        end
        tick();
        checks++;
        if (grant !== 4'b0001 || idx !== 2'd0 || locked !== 1'b1) begin
            errors++;
            $display("FAIL post_reset: grant=%b idx=%0d locked=%b, want 0001/0/1", grant, idx, locked);
        end
    endtask

    initial begin
        test_reset();
        test_grant();
        test_back_to_back();
        test_hold();
        test_idle_fire();
        test_watchdog();
        test_credit();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
